// File: rtl/cus19_wb_seq.sv
// cus19_wb_seq: IE/WB write-back sequencer for the 19-bit core.
// Optional zero flag output when CUS19_WB_ZFLAG_EN is defined.
module cus19_wb_seq #(
    parameter int Data_Width   = 8,
    parameter int Result_Width = 16,
    parameter int Addr_Width   = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    wb_valid_in,
    output logic                    wb_ready_out,
    input  logic [Result_Width-1:0] result_in,
    input  logic [3:0]              funct_op_in,
    input  logic [Addr_Width-1:0]   rd_addr_in,
    output logic                    rf_we_out,
    output logic [Addr_Width-1:0]   rf_waddr_out,
    output logic [Data_Width-1:0]   rf_wdata_out,
`ifdef CUS19_WB_ZFLAG_EN
    output logic                    zero_flag_out,
`endif
    output logic                    busy_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_e;

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    state_e                  state_q;
    logic [Result_Width-1:0] result_q;
    logic [Addr_Width-1:0]   rd_q;
    logic                    wide_q;
    logic                    we_q;
    logic [Addr_Width-1:0]   waddr_q;
    logic [Data_Width-1:0]   wdata_q;
    logic                    ready_q;
    logic                    accept;
    logic                    wide_d;
    logic [Addr_Width-1:0]   rd_hi;

    assign accept = wb_valid_in && ready_q;
    assign wide_d = (funct_op_in == OP_MUL) || (funct_op_in == OP_DIV);
    // High byte lands in the next register, wrapping past the top.
    assign rd_hi  = rd_q + 1'b1;

    // Sequencer FSM with registered write-port and handshake outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            result_q <= '0;
            rd_q     <= '0;
            wide_q   <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b1;
        end else if (accept) begin
            state_q  <= WR_LO;
            result_q <= result_in;
            rd_q     <= rd_addr_in;
            wide_q   <= wide_d;
            we_q     <= 1'b1;
            waddr_q  <= rd_addr_in;
            wdata_q  <= result_in[Data_Width-1:0];
            ready_q  <= !wide_d;
        end else if (state_q == WR_LO && wide_q) begin
            state_q  <= WR_HI;
            we_q     <= 1'b1;
            waddr_q  <= rd_hi;
            wdata_q  <= result_q[Result_Width-1:Data_Width];
            ready_q  <= 1'b1;
        end else begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b1;
        end
    end

`ifdef CUS19_WB_ZFLAG_EN
    logic zflag_q;

    // Zero flag over the full result, refreshed only on accept.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            zflag_q <= 1'b0;
        end else if (accept) begin
            zflag_q <= (result_in == '0);
        end
    end

    assign zero_flag_out = zflag_q;
`endif

    assign wb_ready_out = ready_q;
    assign rf_we_out    = we_q;
    assign rf_waddr_out = waddr_q;
    assign rf_wdata_out = wdata_q;
    assign busy_out     = (state_q != IDLE);

endmodule

// File: tb/tb_cus19_wb_seq.sv
// tb_cus19_wb_seq: directed and randomized checks for cus19_wb_seq.
// Inputs change and outputs are sampled on the falling edge.
module tb_cus19_wb_seq;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [15:0] result;
    logic [3:0]  funct;
    logic [3:0]  rd;
    logic        we;
    logic [3:0]  waddr;
    logic [7:0]  wdata;
    logic        busy;
`ifdef CUS19_WB_ZFLAG_EN
    logic        zf;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] MUL = 4'b0010;
    localparam logic [3:0] DIV = 4'b0011;
    localparam logic [3:0] DEC = 4'b0101;

    cus19_wb_seq dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .wb_valid_in  (valid),
        .wb_ready_out (ready),
        .result_in    (result),
        .funct_op_in  (funct),
        .rd_addr_in   (rd),
        .rf_we_out    (we),
        .rf_waddr_out (waddr),
        .rf_wdata_out (wdata),
`ifdef CUS19_WB_ZFLAG_EN
        .zero_flag_out(zf),
`endif
        .busy_out     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] f,
                         input logic [15:0] r, input logic [3:0] a);
        valid  = v;
        funct  = f;
        result = r;
        rd     = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, ADD, 16'h0, 4'h0);
        @(negedge clk);
        checks++;
        if ({we, waddr, wdata, busy, ready} !== {1'b0, 4'h0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got we=%b a=%h d=%h busy=%b rdy=%b want 0 0 00 0 1",
                     we, waddr, wdata, busy, ready);
        end
        rst_n = 1'b1;
        drive(1'b1, MUL, 16'h1234, 4'd2);
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if ({we, waddr, wdata} !== {1'b1, 4'd2, 8'h34}) begin
            errors++;
            $display("FAIL rst_mid_lo got we=%b a=%h d=%h want 1 2 34", we, waddr, wdata);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({we, waddr, wdata, busy, ready} !== {1'b0, 4'h0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_async got we=%b a=%h d=%h busy=%b rdy=%b want 0 0 00 0 1",
                     we, waddr, wdata, busy, ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({we, busy, ready} !== 3'b001) begin
            errors++;
            $display("FAIL rst_release got we=%b busy=%b rdy=%b want 0 0 1", we, busy, ready);
        end
    endtask

    task automatic test_narrow();
        logic [15:0] rv [3];
        logic [7:0]  dv [3];
        rv = '{16'h0005, 16'h00FF, 16'h0000};
        dv = '{8'h05, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                checks++;
                if ({we, waddr, wdata, ready} !== {1'b1, 4'(i), dv[i-1], 1'b1}) begin
                    errors++;
                    $display("FAIL narrow_%0d got we=%b a=%h d=%h rdy=%b want 1 %h %h 1",
                             i, we, waddr, wdata, ready, 4'(i), dv[i-1]);
                end
            end
            if (i < 3) drive(1'b1, ADD, rv[i], 4'(i + 1));
            else valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({we, waddr, wdata, busy} !== {1'b0, 4'h0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL narrow_idle got we=%b a=%h d=%h busy=%b want 0 0 00 0",
                     we, waddr, wdata, busy);
        end
    endtask

    task automatic test_mul();
        drive(1'b1, MUL, 16'h3A98, 4'd4);
        @(negedge clk);
        checks++;
        if ({we, waddr, wdata, ready, busy} !== {1'b1, 4'd4, 8'h98, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mul_lo got we=%b a=%h d=%h rdy=%b busy=%b want 1 4 98 0 1",
                     we, waddr, wdata, ready, busy);
        end
        drive(1'b1, DEC, 16'h0077, 4'd7);
        @(negedge clk);
        checks++;
        if ({we, waddr, wdata, ready} !== {1'b1, 4'd5, 8'h3A, 1'b1}) begin
            errors++;
            $display("FAIL mul_hi got we=%b a=%h d=%h rdy=%b want 1 5 3a 1",
                     we, waddr, wdata, ready);
        end
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if ({we, waddr, wdata, ready} !== {1'b1, 4'd7, 8'h77, 1'b1}) begin
            errors++;
            $display("FAIL mul_then_dec got we=%b a=%h d=%h rdy=%b want 1 7 77 1",
                     we, waddr, wdata, ready);
        end
        @(negedge clk);
        checks++;
        if ({we, waddr, wdata, busy} !== {1'b0, 4'h0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mul_idle got we=%b a=%h d=%h busy=%b want 0 0 00 0",
                     we, waddr, wdata, busy);
        end
    endtask

    task automatic test_div_wrap();
        drive(1'b1, DIV, 16'h0203, 4'd15);
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if ({we, waddr, wdata} !== {1'b1, 4'd15, 8'h03}) begin
            errors++;
            $display("FAIL div_quot got we=%b a=%h d=%h want 1 f 03", we, waddr, wdata);
        end
        @(negedge clk);
        checks++;
        if ({we, waddr, wdata} !== {1'b1, 4'd0, 8'h02}) begin
            errors++;
            $display("FAIL div_rem_wrap got we=%b a=%h d=%h want 1 0 02", we, waddr, wdata);
        end
        @(negedge clk);
        checks++;
        if ({we, busy} !== 2'b00) begin
            errors++;
            $display("FAIL div_idle got we=%b busy=%b want 0 0", we, busy);
        end
    endtask

    task automatic test_random();
        logic [3:0] eaq [$];
        logic [7:0] edq [$];
        logic [3:0] ea;
        logic [7:0] ed;
        logic       was_ready;
        int         nwr;
        was_ready = 1'b0;
        nwr = 0;
        valid = 1'b0;
        for (int cyc = 0; cyc < 220; cyc++) begin
            @(negedge clk);
            if (we) begin
                checks++;
                nwr++;
                if (eaq.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra_write got a=%h d=%h want no write", waddr, wdata);
                end else begin
                    ea = eaq.pop_front();
                    ed = edq.pop_front();
                    if (waddr !== ea || wdata !== ed) begin
                        errors++;
                        $display("FAIL rnd_write got a=%h d=%h want a=%h d=%h",
                                 waddr, wdata, ea, ed);
                    end
                end
            end
            if (valid && was_ready) valid = 1'b0;
            if (!valid && cyc < 160 && $urandom_range(0, 2) != 0) begin
                drive(1'b1, 4'($urandom_range(0, 15)),
                      16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
                if ($urandom_range(0, 2) == 0) funct = ($urandom_range(0, 1) != 0) ? MUL : DIV;
            end
            if (valid && ready) begin
                eaq.push_back(rd);
                edq.push_back(result[7:0]);
                if (funct == MUL || funct == DIV) begin
                    eaq.push_back(rd + 4'd1);
                    edq.push_back(result[15:8]);
                end
            end
            was_ready = ready;
        end
        valid = 1'b0;
        checks++;
        if (eaq.size() != 0 || nwr < 20) begin
            errors++;
            $display("FAIL rnd_drain got pending=%0d writes=%0d want 0 pending, >=20 writes",
                     eaq.size(), nwr);
        end
    endtask

`ifdef CUS19_WB_ZFLAG_EN
    task automatic test_zflag();
        drive(1'b1, SUB, 16'h0000, 4'd6);
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (zf !== 1'b1) begin
            errors++;
            $display("FAIL zflag_zero got %b want 1", zf);
        end
        @(negedge clk);
        checks++;
        if (zf !== 1'b1) begin
            errors++;
            $display("FAIL zflag_hold got %b want 1", zf);
        end
        drive(1'b1, MUL, 16'h0100, 4'd8);
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (zf !== 1'b0) begin
            errors++;
            $display("FAIL zflag_mul_hi got %b want 0", zf);
        end
        @(negedge clk);
        @(negedge clk);
    endtask
`endif

    initial begin
        void'($urandom(19));
        test_reset();
        test_narrow();
        test_mul();
        test_div_wrap();
        test_random();
`ifdef CUS19_WB_ZFLAG_EN
        test_zflag();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
